// File: rtl/bram_pkg.sv
// Shared BRAM definitions: port widths, the loader/writer state encoding
// and the per-layer base addresses in the shared single-port BRAM.
package bram_pkg;

  localparam int BRAM_ADDR_WIDTH = 18;
  localparam int BRAM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam logic [BRAM_ADDR_WIDTH-1:0] LAYER0_BASE_ADDR = 18'h00000;
  localparam logic [BRAM_ADDR_WIDTH-1:0] LAYER1_BASE_ADDR = 18'h10000;
  localparam logic [BRAM_ADDR_WIDTH-1:0] LAYER2_BASE_ADDR = 18'h20000;
  localparam logic [BRAM_ADDR_WIDTH-1:0] RESULT_BASE_ADDR = 18'h30000;

endpackage

// File: rtl/bram_wr_sequencer.sv
// Element counter and BRAM address generator for one burst of NUM_ELEMS
// consecutive writes; en/wen/addr are registered.
module bram_wr_sequencer
  import bram_pkg::*;
#(
  parameter int          NUM_ELEMS  = 8,
  parameter int          ADDR_WIDTH = BRAM_ADDR_WIDTH,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          CNT_W      = $clog2(NUM_ELEMS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  active,
  output logic                  bram_en,
  output logic                  bram_wen,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [CNT_W-1:0]      idx,
  output logic                  issue,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // last means every element has been issued; the counter reaches NUM_ELEMS
  assign last  = (cnt_q == CNT_W'(NUM_ELEMS));
  assign issue = active && !last;
  assign idx   = cnt_q;

  always_comb begin
    cnt_d  = cnt_q;
    en_d   = 1'b0;
    addr_d = addr_q;
    if (clear) begin
      cnt_d = '0;
    end else if (issue) begin
      cnt_d  = cnt_q + 1'b1;
      en_d   = 1'b1;
      addr_d = BASE + ADDR_WIDTH'(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      en_q   <= 1'b0;
      addr_q <= BASE;
    end else begin
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      addr_q <= addr_d;
    end
  end

  // write-only port: every enabled cycle is a write
  assign bram_en   = en_q;
  assign bram_wen  = en_q;
  assign bram_addr = addr_q;

endmodule

// File: rtl/bram_result_writer.sv
// Writes a layer's flat output vector into the shared BRAM, one element per
// cycle from BASE_ADDR. Optional WRITE_CHECKSUM_EN adds a running element sum.
module bram_result_writer
  import bram_pkg::*;
#(
  parameter int          NUM_ELEMS  = 8,
  parameter int          W          = BRAM_DATA_WIDTH,
  parameter int          ADDR_WIDTH = BRAM_ADDR_WIDTH,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_ELEMS*W-1:0] data_in,
  output logic                   bram_en,
  output logic                   bram_wen,
  output logic [ADDR_WIDTH-1:0]  bram_addr,
  output logic [W-1:0]           bram_din,
  output logic                   busy,
  output logic                   done
`ifdef WRITE_CHECKSUM_EN
  ,
  output logic [W+15:0]          checksum
`endif
);

  localparam int CNT_W = $clog2(NUM_ELEMS + 1);

  state_e                 state_q, state_d;
  logic [NUM_ELEMS*W-1:0] shadow_q, shadow_d;
  logic [W-1:0]           din_q, din_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [W-1:0]           elem;
  logic [CNT_W-1:0]       seq_idx;
  logic                   seq_issue, seq_last, start_ok;

  assign start_ok = start && (state_q == IDLE || state_q == DONE);

  bram_wr_sequencer #(
    .NUM_ELEMS (NUM_ELEMS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .BASE_ADDR (BASE_ADDR),
    .CNT_W     (CNT_W)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .active   (state_q == WRITE),
    .bram_en  (bram_en),
    .bram_wen (bram_wen),
    .bram_addr(bram_addr),
    .idx      (seq_idx),
    .issue    (seq_issue),
    .last     (seq_last)
  );

  always_comb begin
    elem = '0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      if (seq_idx == CNT_W'(i)) elem = shadow_q[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = WRITE;
      WRITE:   if (seq_last) state_d = DONE;
      DONE:    if (start) state_d = WRITE;
      default: state_d = IDLE;
    endcase
  end

  // registered outputs are computed one edge ahead from the current state
  always_comb begin
    shadow_d = shadow_q;
    din_d    = din_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) shadow_d = data_in;
      WRITE: begin
        if (seq_issue) begin
          busy_d = 1'b1;
          din_d  = elem;
        end else begin
          done_d = 1'b1;
        end
      end
      DONE: begin
        if (start) shadow_d = data_in;
        else       done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      din_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      din_q    <= din_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bram_din = din_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef WRITE_CHECKSUM_EN
  logic [W+15:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (start_ok)       chk_d = '0;
    else if (seq_issue) chk_d = chk_q + (W+16)'(elem);
  end

  always_ff @(posedge clk) begin
    if (rst) chk_q <= '0;
    else     chk_q <= chk_d;
  end

  assign checksum = chk_q;
`endif

endmodule

// File: tb/tb_bram_result_writer.sv
// Scoreboard bench for bram_result_writer: stimulus pushes expected BRAM
// writes, per-instance monitors pop and compare them and keep a BRAM model.
module tb_bram_result_writer;

  typedef struct packed {
    logic [17:0] addr;
    logic [7:0]  din;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [63:0] data_a;
  logic [31:0] data_b;

  logic        a_en, a_wen, a_busy, a_done;
  logic [17:0] a_addr;
  logic [7:0]  a_din;
  logic        b_en, b_wen, b_busy, b_done;
  logic [17:0] b_addr;
  logic [7:0]  b_din;
`ifdef WRITE_CHECKSUM_EN
  logic [23:0] a_checksum, b_checksum;
`endif

  wr_t        qa[$];
  wr_t        qb[$];
  logic [7:0] mem_a [int];
  logic [7:0] mem_b [int];
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  bram_result_writer #(.NUM_ELEMS(8), .W(8), .ADDR_WIDTH(18), .BASE_ADDR(100)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data_in(data_a),
    .bram_en(a_en), .bram_wen(a_wen), .bram_addr(a_addr), .bram_din(a_din),
    .busy(a_busy), .done(a_done)
`ifdef WRITE_CHECKSUM_EN
    , .checksum(a_checksum)
`endif
  );

  bram_result_writer #(.NUM_ELEMS(4), .W(8), .ADDR_WIDTH(18), .BASE_ADDR(262142)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data_in(data_b),
    .bram_en(b_en), .bram_wen(b_wen), .bram_addr(b_addr), .bram_din(b_din),
    .busy(b_busy), .done(b_done)
`ifdef WRITE_CHECKSUM_EN
    , .checksum(b_checksum)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pushExpectA(input logic [63:0] data);
    for (int k = 0; k < 8; k++) qa.push_back('{addr: 18'(100 + k), din: data[k*8 +: 8]});
  endtask

  task automatic applyStimulus(input logic [63:0] data);
    pushExpectA(data);
    data_a  = data;
    start_a = 1'b1;
  endtask

  task automatic applyStimulusB(input logic [31:0] data);
    for (int k = 0; k < 4; k++) qb.push_back('{addr: 18'(262142 + k), din: data[k*8 +: 8]});
    data_b  = data;
    start_b = 1'b1;
  endtask

  // monitors: every enabled cycle must match the head of the queue
  always @(negedge clk) begin : mon_a
    wr_t e;
    checkOutput("a_wen_eq_en", {31'd0, a_wen}, {31'd0, a_en});
    if (a_en) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL a_unexpected_write addr=%0d din=0x%0h", a_addr, a_din);
      end else begin
        e = qa.pop_front();
        checkOutput("a_addr", {14'd0, a_addr}, {14'd0, e.addr});
        checkOutput("a_din", {24'd0, a_din}, {24'd0, e.din});
      end
      mem_a[int'(a_addr)] = a_din;
    end
  end

  always @(negedge clk) begin : mon_b
    wr_t e;
    checkOutput("b_wen_eq_en", {31'd0, b_wen}, {31'd0, b_en});
    if (b_en) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL b_unexpected_write addr=%0d din=0x%0h", b_addr, b_din);
      end else begin
        e = qb.pop_front();
        checkOutput("b_addr", {14'd0, b_addr}, {14'd0, e.addr});
        checkOutput("b_din", {24'd0, b_din}, {24'd0, e.din});
      end
      mem_b[int'(b_addr)] = b_din;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stim
    int n;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
    tick(); tick();

    checkOutput("rst_a_en", {31'd0, a_en}, 0);
    checkOutput("rst_a_addr", {14'd0, a_addr}, 100);
    checkOutput("rst_a_din", {24'd0, a_din}, 0);
    checkOutput("rst_a_busy", {31'd0, a_busy}, 0);
    checkOutput("rst_a_done", {31'd0, a_done}, 0);
    checkOutput("rst_b_addr", {14'd0, b_addr}, 262142);
    rst = 1'b0;
    tick();

    // basic transfer, with data_in scrambled right after capture
    applyStimulus(64'h8877665544332211);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) begin
        start_a = 1'b0;
        data_a  = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      checkOutput($sformatf("basic_busy_c%0d", i), {31'd0, a_busy}, (i >= 2 && i <= 9) ? 1 : 0);
      checkOutput($sformatf("basic_done_c%0d", i), {31'd0, a_done}, (i == 10) ? 1 : 0);
    end
    checkOutput("basic_queue_drained", qa.size(), 0);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("basic_readback_%0d", 100 + k), {24'd0, mem_a[100 + k]}, 32'h11 * (k + 1));
`ifdef WRITE_CHECKSUM_EN
    checkOutput("basic_checksum", {8'd0, a_checksum}, 32'h264);
`endif
    tick(); tick();
    checkOutput("done_held", {31'd0, a_done}, 1);

    // reset after the third write of a new transfer
    applyStimulus(64'hC7C6C5C4C3C2C1C0);
    tick();
    start_a = 1'b0;
    checkOutput("restart_clears_done", {31'd0, a_done}, 0);
`ifdef WRITE_CHECKSUM_EN
    checkOutput("checksum_cleared_on_start", {8'd0, a_checksum}, 0);
`endif
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    checkOutput("midrst_en", {31'd0, a_en}, 0);
    checkOutput("midrst_wen", {31'd0, a_wen}, 0);
    checkOutput("midrst_busy", {31'd0, a_busy}, 0);
    checkOutput("midrst_done", {31'd0, a_done}, 0);
    checkOutput("midrst_addr", {14'd0, a_addr}, 100);
    checkOutput("midrst_remaining", qa.size(), 5);
    qa.delete();
    rst = 1'b0;
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("midrst_readback_%0d", 100 + k), {24'd0, mem_a[100 + k]},
                  (k < 3) ? (32'hC0 + k) : (32'h11 * (k + 1)));

    // back-to-back: start held through DONE
    tick();
    applyStimulus(64'h8877665544332211);
    n = 0;
    do begin tick(); n++; end while (!a_done && n < 20);
    checkOutput("b2b_first_done", {31'd0, a_done}, 1);
    checkOutput("b2b_latency", n, 10);
    pushExpectA(64'hA7A6A5A4A3A2A1A0);
    data_a = 64'hA7A6A5A4A3A2A1A0;
    tick();
    start_a = 1'b0;
    checkOutput("b2b_done_dropped", {31'd0, a_done}, 0);
    tick();
    checkOutput("b2b_second_busy", {31'd0, a_busy}, 1);
    n = 0;
    do begin tick(); n++; end while (!a_done && n < 20);
    checkOutput("b2b_second_done", {31'd0, a_done}, 1);
    checkOutput("b2b_queue_drained", qa.size(), 0);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("b2b_readback_%0d", 100 + k), {24'd0, mem_a[100 + k]}, 32'hA0 + k);

    // address wrap on the second instance
    applyStimulusB(32'h44332211);
    n = 0;
    do begin
      tick();
      n++;
      start_b = 1'b0;
    end while (!b_done && n < 20);
    checkOutput("wrap_latency", n, 6);
    checkOutput("wrap_queue_drained", qb.size(), 0);
    checkOutput("wrap_mem_262142", {24'd0, mem_b[262142]}, 32'h11);
    checkOutput("wrap_mem_262143", {24'd0, mem_b[262143]}, 32'h22);
    checkOutput("wrap_mem_0", {24'd0, mem_b[0]}, 32'h33);
    checkOutput("wrap_mem_1", {24'd0, mem_b[1]}, 32'h44);
`ifdef WRITE_CHECKSUM_EN
    checkOutput("wrap_checksum", {8'd0, b_checksum}, 32'hAA);
`endif

    tick(); tick();
    checkOutput("final_qa_empty", qa.size(), 0);
    checkOutput("final_qb_empty", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
